// File: rtl/fifo_pkg.sv
// Shared types and parameter-legality helpers for the parametrised sync FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int unsigned dwidth,
                                        input int unsigned depth,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
    return (dwidth >= 1) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bundle of the FIFO; master drives requests, slave is the FIFO.
interface fifo_param_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DWIDTH-1:0] din;
  logic              rd;
  logic [DWIDTH-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, din, rd,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, din, rd,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DWIDTH register array: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DWIDTH-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DWIDTH-1:0]        rdata_o
);
  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; pointers and count guard against stale reads.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, count, registered flags, error pulses and read-mode mux.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (!fifo_params_ok(DWIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal DWIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_status_t      status_q, status_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] rdata;
  logic              ovf_q, unf_q;
  logic              wa, ra;

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wa),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  // Flags are registered from count_d so every output is a flop, glitch-free.
  always_comb begin
    wa     = bus.wr && !status_q.full;
    ra     = bus.rd && !status_q.empty;
    wptr_d = wa ? wptr_q + PW'(1) : wptr_q;
    rptr_d = ra ? rptr_q + PW'(1) : rptr_q;
    dout_d = ra ? rdata : dout_q;
    unique case ({wa, ra})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    status_d.full         = (count_d == CW'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    status_d.almost_empty = (count_d <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      status_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      status_q <= status_d;
      dout_q   <= dout_d;
      ovf_q    <= bus.wr && status_q.full;
      unf_q    <= bus.rd && status_q.empty;
    end
  end

  assign bus.dout         = (FWFT != 0) ? (status_q.empty ? '0 : rdata) : dout_q;
  assign bus.count        = count_q;
  assign bus.full         = status_q.full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: standard and FWFT instances driven identically, checked against a queue model.
module tb_sync_fifo_param;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 14;
  localparam int unsigned AEL   = 2;

  logic clk;
  logic rst;

  fifo_param_if #(.DWIDTH(DW), .DEPTH(DEPTH)) if_std ();
  fifo_param_if #(.DWIDTH(DW), .DEPTH(DEPTH)) if_fw ();

  sync_fifo_param #(.DWIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(if_std.slave));
  sync_fifo_param #(.DWIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1))
    u_fw (.clk(clk), .rst(rst), .bus(if_fw.slave));

  typedef struct {
    int          count;
    bit          full, empty, af, ae, ovf, unf;
    logic [7:0]  dstd, dfw;
  } st_t;

  int         checks   = 0;
  int         failures = 0;
  bit         mon_en   = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_std_q[$];
  logic [7:0] exp_fw_q[$];
  st_t        st_q[$];
  logic [7:0] last_std = '0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] cnt, input logic f, input logic e,
                            input logic af, input logic ae, input logic ov, input logic un,
                            input logic [7:0] d, input st_t x, input bit fw);
    chk({tag, ".count"}, cnt, x.count);
    chk({tag, ".full"}, f, x.full);
    chk({tag, ".empty"}, e, x.empty);
    chk({tag, ".almost_full"}, af, x.af);
    chk({tag, ".almost_empty"}, ae, x.ae);
    chk({tag, ".overflow"}, ov, x.ovf);
    chk({tag, ".underflow"}, un, x.unf);
    chk({tag, ".dout"}, d, fw ? x.dfw : x.dstd);
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.count = 0; s.full = 0; s.empty = 1; s.af = 0; s.ae = 1;
    s.ovf = 0; s.unf = 0; s.dstd = '0; s.dfw = '0;
    return s;
  endfunction

  // One clock of stimulus: drive at negedge, advance the queue model, queue expectations.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    st_t e;
    bit  mf, me;
    logic [7:0] v;
    @(negedge clk);
    if_std.wr = w; if_std.din = d; if_std.rd = r;
    if_fw.wr  = w; if_fw.din  = d; if_fw.rd  = r;
    mf = (mdl.size() == DEPTH);
    me = (mdl.size() == 0);
    if (r && !me) begin
      v = mdl.pop_front();
      exp_std_q.push_back(v);
      exp_fw_q.push_back(v);
      last_std = v;
    end
    if (w && !mf) mdl.push_back(d);
    e.count = mdl.size();
    e.full  = (mdl.size() == DEPTH);
    e.empty = (mdl.size() == 0);
    e.af    = (mdl.size() >= AFL);
    e.ae    = (mdl.size() <= AEL);
    e.ovf   = w && mf;
    e.unf   = r && me;
    e.dstd  = last_std;
    e.dfw   = (mdl.size() != 0) ? mdl[0] : 8'h00;
    st_q.push_back(e);
  endtask

  initial begin : status_monitor
    st_t e;
    forever begin
      @(posedge clk);
      if (mon_en && st_q.size() > 0) begin
        #1;
        e = st_q.pop_front();
        check_outs("std", if_std.count, if_std.full, if_std.empty, if_std.almost_full,
                   if_std.almost_empty, if_std.overflow, if_std.underflow, if_std.dout, e, 0);
        check_outs("fwft", if_fw.count, if_fw.full, if_fw.empty, if_fw.almost_full,
                   if_fw.almost_empty, if_fw.overflow, if_fw.underflow, if_fw.dout, e, 1);
      end
    end
  end

  initial begin : std_data_monitor
    bit ra;
    forever begin
      @(posedge clk);
      if (mon_en) begin
        ra = if_std.rd && !if_std.empty;
        #1;
        if (ra) begin
          if (exp_std_q.size() == 0) chk("std_unexpected_pop", 1, 0);
          else chk("std_rdata", if_std.dout, exp_std_q.pop_front());
        end
      end
    end
  end

  initial begin : fw_data_monitor
    forever begin
      @(posedge clk);
      if (mon_en && if_fw.rd && !if_fw.empty) begin
        if (exp_fw_q.size() == 0) chk("fwft_unexpected_pop", 1, 0);
        else chk("fwft_rdata", if_fw.dout, exp_fw_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    st_t rs;
    rs  = reset_state();
    rst = 1;
    if_std.wr = 0; if_std.rd = 0; if_std.din = '0;
    if_fw.wr  = 0; if_fw.rd  = 0; if_fw.din  = '0;
    repeat (2) @(negedge clk);
    check_outs("reset_std", if_std.count, if_std.full, if_std.empty, if_std.almost_full,
               if_std.almost_empty, if_std.overflow, if_std.underflow, if_std.dout, rs, 0);
    check_outs("reset_fwft", if_fw.count, if_fw.full, if_fw.empty, if_fw.almost_full,
               if_fw.almost_empty, if_fw.overflow, if_fw.underflow, if_fw.dout, rs, 1);
    rst    = 0;
    mon_en = 1;

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0);
    cycle(1, 8'hAA, 0);
    cycle(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Offset pointers so the level-5 streaming run wraps them.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'($urandom), 0);
      cycle(0, 8'h00, 1);
    end
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0);
    for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);

    // FWFT fall-through of a single word into an empty FIFO.
    cycle(1, 8'h5C, 0);
    @(posedge clk); #2;
    chk("fwft_fallthrough_dout", if_fw.dout, 8'h5C);
    cycle(0, 8'h00, 1);
    @(posedge clk); #2;
    chk("fwft_after_pop_dout", if_fw.dout, 8'h00);
    chk("fwft_after_pop_empty", if_fw.empty, 1);

    // Randomised traffic with alternating fill/drain bias.
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw));
    end
    while (mdl.size() > 0) cycle(0, 8'h00, 1);

    // Asynchronous reset mid-cycle at level 9.
    for (int i = 0; i < 9; i++) cycle(1, 8'($urandom), 0);
    cycle(0, 8'h00, 0);
    @(negedge clk);
    mon_en = 0;
    if_std.wr = 0; if_std.rd = 0; if_fw.wr = 0; if_fw.rd = 0;
    #2 rst = 1;
    #1;
    check_outs("midreset_std", if_std.count, if_std.full, if_std.empty, if_std.almost_full,
               if_std.almost_empty, if_std.overflow, if_std.underflow, if_std.dout, rs, 0);
    check_outs("midreset_fwft", if_fw.count, if_fw.full, if_fw.empty, if_fw.almost_full,
               if_fw.almost_empty, if_fw.overflow, if_fw.underflow, if_fw.dout, rs, 1);
    mdl.delete();
    exp_std_q.delete();
    exp_fw_q.delete();
    st_q.delete();
    last_std = '0;
    @(negedge clk);
    rst    = 0;
    mon_en = 1;
    cycle(1, 8'h11, 0);
    cycle(0, 8'h00, 1);
    @(posedge clk); #2;
    chk("post_reset_std_dout", if_std.dout, 8'h11);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    @(posedge clk); #2;
    chk("std_scoreboard_drained", exp_std_q.size(), 0);
    chk("fwft_scoreboard_drained", exp_fw_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
